// File: rtl/iob_fp_div_pkg.sv
// Shared types for the iterative FP divider: FSM encoding, operand class, rounding width.
package iob_fp_div_pkg;

  // Guard, round and sticky bits carried into the rounder
  localparam int unsigned EXTRA = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_RND  = 2'd2
  } state_e;

  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic is_zero;
  } fp_class_t;

endpackage

// File: rtl/iob_fp_div_if.sv
// Start/done handshake, operands, result and flags of the FP divider.
interface iob_fp_div_if #(
  parameter int unsigned DATA_W = 32
);
  logic              start_i;
  logic [DATA_W-1:0] op_a_i;
  logic [DATA_W-1:0] op_b_i;
  logic              done_o;
  logic [DATA_W-1:0] res_o;
  logic              overflow_o;
  logic              underflow_o;
  logic              exception_o;

  modport master (
    output start_i, op_a_i, op_b_i,
    input  done_o, res_o, overflow_o, underflow_o, exception_o
  );

  modport slave (
    input  start_i, op_a_i, op_b_i,
    output done_o, res_o, overflow_o, underflow_o, exception_o
  );
endinterface

// File: rtl/iob_fp_div_man.sv
// Restoring mantissa divider: one quotient bit per cycle, MAN_W+2 bits plus sticky.
module iob_fp_div_man #(
  parameter int unsigned MAN_W = 24
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             load_i,
  input  logic [MAN_W:0]   dividend_i,
  input  logic [MAN_W-1:0] divisor_i,
  output logic [MAN_W+1:0] quot_o,
  output logic             sticky_c,
  output logic             last_c
);
  localparam int unsigned QUO_W = MAN_W + 2;
  localparam int unsigned REM_W = MAN_W + 2;
  localparam int unsigned CNT_W = $clog2(QUO_W + 1);

  logic [REM_W-1:0] rem_q, rem_d;
  logic [MAN_W-1:0] div_q, div_d;
  logic [QUO_W-1:0] quot_q, quot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REM_W-1:0] trial;
  logic             ge;

  // Load operands, then one trial subtraction per cycle until the counter drains
  always_comb begin
    rem_d  = rem_q;
    div_d  = div_q;
    quot_d = quot_q;
    cnt_d  = cnt_q;
    ge     = rem_q >= REM_W'(div_q);
    trial  = rem_q - REM_W'(div_q);
    if (load_i) begin
      rem_d  = REM_W'(dividend_i);
      div_d  = divisor_i;
      quot_d = '0;
      cnt_d  = CNT_W'(QUO_W);
    end else if (cnt_q != '0) begin
      rem_d  = (ge ? trial : rem_q) << 1;
      quot_d = {quot_q[QUO_W-2:0], ge};
      cnt_d  = cnt_q - CNT_W'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rem_q  <= '0;
      div_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      div_q  <= div_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_d;
    end
  end

  assign quot_o   = quot_q;
  assign sticky_c = |rem_q;
  assign last_c   = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/iob_fp_round.sv
// Round-to-nearest-even of {mantissa, guard, round, sticky}; carry flags a renormalizing overflow.
module iob_fp_round
  import iob_fp_div_pkg::*;
#(
  parameter int unsigned MAN_W = 24
) (
  input  logic [MAN_W+EXTRA-1:0] in_i,
  output logic [MAN_W-2:0]       frac_c,
  output logic                   carry_c
);
  logic [MAN_W-1:0] man;
  logic             lsb;
  logic             guard;
  logic             rest;
  logic             up;
  logic [MAN_W:0]   sum;

  // Increment on > half, or exactly half with odd lsb; shift right on carry-out
  always_comb begin
    man     = in_i[MAN_W+EXTRA-1:EXTRA];
    lsb     = in_i[EXTRA];
    guard   = in_i[EXTRA-1];
    rest    = |in_i[EXTRA-2:0];
    up      = guard & (rest | lsb);
    sum     = {1'b0, man} + (MAN_W+1)'(up);
    carry_c = sum[MAN_W];
    frac_c  = carry_c ? sum[MAN_W-1:1] : sum[MAN_W-2:0];
  end

endmodule

// File: rtl/iob_fp_special.sv
// Operand unpacking and classification; subnormals are treated as zero.
module iob_fp_special
  import iob_fp_div_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned EXP_W  = 8
) (
  input  logic [DATA_W-1:0]       op_i,
  output fp_class_t               cls_c,
  output logic                    sign_c,
  output logic [EXP_W-1:0]        exp_c,
  output logic [DATA_W-EXP_W-1:0] man_c
);
  localparam int unsigned MAN_W  = DATA_W - EXP_W;
  localparam int unsigned FRAC_W = MAN_W - 1;

  logic [FRAC_W-1:0] frac;
  logic              exp_ones;

  // Field split and class decode
  always_comb begin
    sign_c        = op_i[DATA_W-1];
    exp_c         = op_i[DATA_W-2:FRAC_W];
    frac          = op_i[FRAC_W-1:0];
    exp_ones      = &exp_c;
    cls_c.is_nan  = exp_ones & (|frac);
    cls_c.is_inf  = exp_ones & ~(|frac);
    cls_c.is_zero = ~(|exp_c);
    man_c         = cls_c.is_zero ? '0 : {1'b1, frac};
  end

endmodule

// File: rtl/iob_fp_div.sv
// Iterative floating-point divider, fixed latency of MAN_W+3 cycles from start to done.
module iob_fp_div
  import iob_fp_div_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned EXP_W  = 8
) (
  input logic         clk_i,
  input logic         arst_n_i,
  iob_fp_div_if.slave bus
);
  localparam int unsigned MAN_W  = DATA_W - EXP_W;
  localparam int unsigned FRAC_W = MAN_W - 1;
  localparam int unsigned E_W    = EXP_W + 2;
  localparam int unsigned QUO_W  = MAN_W + 2;
  localparam int unsigned BIAS   = (1 << (EXP_W - 1)) - 1;
  localparam logic [E_W-1:0] E_MAX = E_W'((1 << EXP_W) - 1);

  fp_class_t        cls_a_c, cls_b_c;
  logic             sign_a_c, sign_b_c;
  logic [EXP_W-1:0] exp_a_c, exp_b_c;
  logic [MAN_W-1:0] man_a_c, man_b_c;
  logic             prenorm_c;
  logic [MAN_W:0]   dividend_c;
  logic             load_c;

  logic [QUO_W-1:0]  quot;
  logic              sticky_c;
  logic              last_c;
  logic [FRAC_W-1:0] frac_c;
  logic              carry_c;
  logic [E_W-1:0]    e_rnd_c;

  state_e            state_q, state_d;
  logic              sign_q, sign_d;
  fp_class_t         cls_a_q, cls_a_d, cls_b_q, cls_b_d;
  logic [E_W-1:0]    exp_q, exp_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              ovf_q, ovf_d, unf_q, unf_d, exc_q, exc_d, done_q, done_d;

  iob_fp_special #(.DATA_W(DATA_W), .EXP_W(EXP_W)) u_spec_a (
    .op_i  (bus.op_a_i),
    .cls_c (cls_a_c),
    .sign_c(sign_a_c),
    .exp_c (exp_a_c),
    .man_c (man_a_c)
  );

  iob_fp_special #(.DATA_W(DATA_W), .EXP_W(EXP_W)) u_spec_b (
    .op_i  (bus.op_b_i),
    .cls_c (cls_b_c),
    .sign_c(sign_b_c),
    .exp_c (exp_b_c),
    .man_c (man_b_c)
  );

  // Pre-normalize so the first quotient bit is always the hidden one
  assign prenorm_c  = man_a_c < man_b_c;
  assign dividend_c = prenorm_c ? {man_a_c, 1'b0} : {1'b0, man_a_c};

  iob_fp_div_man #(.MAN_W(MAN_W)) u_div_man (
    .clk_i     (clk_i),
    .arst_n_i  (arst_n_i),
    .load_i    (load_c),
    .dividend_i(dividend_c),
    .divisor_i (man_b_c),
    .quot_o    (quot),
    .sticky_c  (sticky_c),
    .last_c    (last_c)
  );

  iob_fp_round #(.MAN_W(MAN_W)) u_round (
    .in_i   ({quot, sticky_c}),
    .frac_c (frac_c),
    .carry_c(carry_c)
  );

  assign e_rnd_c = exp_q + E_W'(carry_c);

  // Next state, operand capture and result selection with special-case priority
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    sign_d  = sign_q;
    cls_a_d = cls_a_q;
    cls_b_d = cls_b_q;
    exp_d   = exp_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    exc_d   = exc_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          state_d = ST_DIV;
          load_c  = 1'b1;
          sign_d  = sign_a_c ^ sign_b_c;
          cls_a_d = cls_a_c;
          cls_b_d = cls_b_c;
          exp_d   = E_W'(exp_a_c) - E_W'(exp_b_c) + E_W'(BIAS) - E_W'(prenorm_c);
        end
      end
      ST_DIV: begin
        if (last_c) state_d = ST_RND;
      end
      ST_RND: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        exc_d   = 1'b0;
        if (cls_a_q.is_nan || cls_b_q.is_nan ||
            (cls_a_q.is_inf && cls_b_q.is_inf) || (cls_a_q.is_zero && cls_b_q.is_zero)) begin
          res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
          exc_d = 1'b1;
        end else if (cls_b_q.is_zero && !cls_a_q.is_inf) begin
          res_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          exc_d = 1'b1;
        end else if (cls_a_q.is_inf) begin
          res_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (cls_b_q.is_inf || cls_a_q.is_zero) begin
          res_d = {sign_q, {(DATA_W-1){1'b0}}};
        end else if (!e_rnd_c[E_W-1] && (e_rnd_c >= E_MAX)) begin
          res_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          ovf_d = 1'b1;
        end else if (e_rnd_c[E_W-1] || (e_rnd_c == '0)) begin
          res_d = {sign_q, {(DATA_W-1){1'b0}}};
          unf_d = 1'b1;
        end else begin
          res_d = {sign_q, e_rnd_c[EXP_W-1:0], frac_c};
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, captured operand info and registered outputs
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      cls_a_q <= '0;
      cls_b_q <= '0;
      exp_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      exc_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      cls_a_q <= cls_a_d;
      cls_b_q <= cls_b_d;
      exp_q   <= exp_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      exc_q   <= exc_d;
      done_q  <= done_d;
    end
  end

  assign bus.done_o      = done_q;
  assign bus.res_o       = res_q;
  assign bus.overflow_o  = ovf_q;
  assign bus.underflow_o = unf_q;
  assign bus.exception_o = exc_q;

endmodule

// File: tb/tb_iob_fp_div.sv
// Self-checking bench for iob_fp_div: directed vectors, random operands vs. an exact-arithmetic model.
module tb_iob_fp_div;

  localparam int LAT = 27;

  logic clk = 1'b0;
  logic arst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  iob_fp_div_if #(.DATA_W(32)) bus ();

  iob_fp_div #(.DATA_W(32), .EXP_W(8)) dut (
    .clk_i   (clk),
    .arst_n_i(arst_n),
    .bus     (bus)
  );

  // Reference: exact integer quotient with RNE on the true remainder; returns {res, ovf, unf, exc}
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
    logic              sa, sb, s;
    logic [7:0]        ea, eb;
    logic [22:0]       fa, fb;
    logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    longint unsigned   ma, mb, num, q, rem;
    int                e;
    sa = a[31]; ea = a[30:23]; fa = a[22:0];
    sb = b[31]; eb = b[30:23]; fb = b[22:0];
    s = sa ^ sb;
    nan_a = (ea == 8'hFF) && (fa != 0);  inf_a = (ea == 8'hFF) && (fa == 0);  zero_a = (ea == 0);
    nan_b = (eb == 8'hFF) && (fb != 0);  inf_b = (eb == 8'hFF) && (fb == 0);  zero_b = (eb == 0);
    if (nan_a || nan_b) return {32'h7FC00000, 3'b001};
    if ((inf_a && inf_b) || (zero_a && zero_b)) return {32'h7FC00000, 3'b001};
    if (zero_b && !inf_a) return {s, 8'hFF, 23'd0, 3'b001};
    if (inf_a) return {s, 8'hFF, 23'd0, 3'b000};
    if (inf_b || zero_a) return {s, 31'd0, 3'b000};
    ma = 64'(fa) + 64'h800000;
    mb = 64'(fb) + 64'h800000;
    e  = int'(ea) - int'(eb) + 127;
    if (ma < mb) begin
      num = ma << 24;
      e   = e - 1;
    end else begin
      num = ma << 23;
    end
    q   = num / mb;
    rem = num - q * mb;
    if ((2 * rem > mb) || ((2 * rem == mb) && q[0])) q = q + 1;
    if (q == 64'h1000000) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0, 3'b100};
    if (e <= 0) return {s, 31'd0, 3'b010};
    return {s, 8'(e), 23'(q), 3'b000};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: v[30:0] = '0;
      1: v[30:0] = {8'hFF, 23'd0};
      2: v[30:22] = 9'h1FF;
      3: v[30:23] = 8'h00;
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  // Drive one start pulse; returns #1 after the sampling edge with operands scrambled
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_a_i  = a;
    bus.op_b_i  = b;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.op_a_i  = $urandom;
    bus.op_b_i  = $urandom;
  endtask

  // Count edges until done_o (bounded); n0 = edges already elapsed since start
  task automatic wait_done(input int n0, output int n, output logic [34:0] got);
    n = n0;
    while (bus.done_o !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    got = {bus.res_o, bus.overflow_o, bus.underflow_o, bus.exception_o};
  endtask

  task automatic test_reset();
    arst_n      = 1'b0;
    bus.start_i = 1'b0;
    bus.op_a_i  = '0;
    bus.op_b_i  = '0;
    #1;
    checks++;
    if ({bus.done_o, bus.res_o, bus.overflow_o, bus.underflow_o, bus.exception_o} !== 36'd0) begin
      failures++;
      $display("FAIL reset_state: got done=%b res=%h flags=%b%b%b expected all zero",
               bus.done_o, bus.res_o, bus.overflow_o, bus.underflow_o, bus.exception_o);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] va [10] = '{32'h40C00000, 32'h3F800000, 32'hC0000000, 32'h3F800000, 32'h00000000,
                             32'h7FC00001, 32'h7F000000, 32'h00800000, 32'h7F800000, 32'h80000000};
    logic [31:0] vb [10] = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h00000000, 32'h00000000,
                             32'h3F800000, 32'h3E800000, 32'h40000000, 32'h00000000, 32'h3F800000};
    logic [34:0] ve [10] = '{{32'h40400000, 3'b000}, {32'h3EAAAAAB, 3'b000}, {32'hC0000000, 3'b000},
                             {32'h7F800000, 3'b001}, {32'h7FC00000, 3'b001}, {32'h7FC00000, 3'b001},
                             {32'h7F800000, 3'b100}, {32'h00000000, 3'b010}, {32'h7F800000, 3'b000},
                             {32'h80000000, 3'b000}};
    int          n;
    logic [34:0] got;
    for (int i = 0; i < 10; i++) begin
      start_op(va[i], vb[i]);
      wait_done(0, n, got);
      checks++;
      if (got !== ve[i]) begin
        failures++;
        $display("FAIL directed_%0d %h/%h: got res=%h ovf/unf/exc=%b expected res=%h ovf/unf/exc=%b",
                 i, va[i], vb[i], got[34:3], got[2:0], ve[i][34:3], ve[i][2:0]);
      end
      checks++;
      if (n !== LAT) begin
        failures++;
        $display("FAIL directed_latency_%0d: got %0d edges expected %0d", i, n, LAT);
      end
    end
  endtask

  task automatic test_random();
    int          n;
    logic [31:0] a, b;
    logic [34:0] got, exp;
    for (int i = 0; i < 60; i++) begin
      a   = rand_op();
      b   = rand_op();
      exp = model(a, b);
      start_op(a, b);
      wait_done(0, n, got);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random_%0d %h/%h: got res=%h ovf/unf/exc=%b expected res=%h ovf/unf/exc=%b",
                 i, a, b, got[34:3], got[2:0], exp[34:3], exp[2:0]);
      end
      checks++;
      if (n !== LAT) begin
        failures++;
        $display("FAIL random_latency_%0d: got %0d edges expected %0d", i, n, LAT);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int          n, ndone;
    logic [34:0] got;
    start_op(32'h40C00000, 32'h40000000);
    n = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.start_i = 1'b1;
    bus.op_a_i  = 32'h3F800000;
    bus.op_b_i  = 32'h40400000;
    @(posedge clk);
    #1;
    n++;
    bus.start_i = 1'b0;
    wait_done(n, n, got);
    checks++;
    if (got !== {32'h40400000, 3'b000}) begin
      failures++;
      $display("FAIL busy_result: got res=%h flags=%b expected res=40400000 flags=000", got[34:3], got[2:0]);
    end
    checks++;
    if (n !== LAT) begin
      failures++;
      $display("FAIL busy_latency: got %0d edges expected %0d", n, LAT);
    end
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done_o === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      failures++;
      $display("FAIL busy_extra_done: got %0d extra done pulses expected 0", ndone);
    end
  endtask

  task automatic test_back_to_back();
    int          n;
    logic [34:0] got;
    start_op(32'h40C00000, 32'h40000000);
    wait_done(0, n, got);
    checks++;
    if (got !== {32'h40400000, 3'b000} || n !== LAT) begin
      failures++;
      $display("FAIL b2b_first: got res=%h edges=%0d expected res=40400000 edges=%0d", got[34:3], n, LAT);
    end
    bus.start_i = 1'b1;
    bus.op_a_i  = 32'h3F800000;
    bus.op_b_i  = 32'h40400000;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    checks++;
    if (bus.done_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done_pulse: got done=%b expected 0 one cycle after done", bus.done_o);
    end
    wait_done(0, n, got);
    checks++;
    if (got !== {32'h3EAAAAAB, 3'b000}) begin
      failures++;
      $display("FAIL b2b_second: got res=%h flags=%b expected res=3eaaaaab flags=000", got[34:3], got[2:0]);
    end
    checks++;
    if (n !== LAT) begin
      failures++;
      $display("FAIL b2b_latency: got %0d edges expected %0d", n, LAT);
    end
  endtask

  task automatic test_reset_mid_op();
    int          n, ndone;
    logic [34:0] got;
    start_op(32'h7F000000, 32'h3E800000);
    repeat (9) @(posedge clk);
    #1;
    arst_n = 1'b0;
    #1;
    checks++;
    if ({bus.done_o, bus.res_o, bus.overflow_o, bus.underflow_o, bus.exception_o} !== 36'd0) begin
      failures++;
      $display("FAIL midop_reset_outputs: got done=%b res=%h flags=%b%b%b expected all zero",
               bus.done_o, bus.res_o, bus.overflow_o, bus.underflow_o, bus.exception_o);
    end
    @(negedge clk);
    arst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done_o === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      failures++;
      $display("FAIL midop_no_done: got %0d done pulses expected 0", ndone);
    end
    start_op(32'h40C00000, 32'h40000000);
    wait_done(0, n, got);
    checks++;
    if (got !== {32'h40400000, 3'b000} || n !== LAT) begin
      failures++;
      $display("FAIL midop_recover: got res=%h flags=%b edges=%0d expected res=40400000 flags=000 edges=%0d",
               got[34:3], got[2:0], n, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iob_fp_div.md
Name: iob_fp_div

Overview:
- Iterative IEEE-754-style floating-point divider: res = op_a / op_b.
- Inverse companion of the pipelined FP multiplier; shares its DATA_W/EXP_W format, start/done handshake and flag ports.
- Restoring mantissa division produces one quotient bit per cycle, followed by a round-to-nearest-even stage.
- Intended for low-area datapaths where division is infrequent.

Parameters:
- DATA_W, 32: total word width (sign + exponent + fraction).
- EXP_W, 8: exponent width. Derived values: MAN_W = DATA_W-EXP_W (hidden bit + fraction); BIAS = 2^(EXP_W-1)-1; EXTRA = 3 (guard, round, sticky).

Ports:
- clk_i, in, 1: clock, rising edge.
- arst_n_i, in, 1: asynchronous active-low reset.
- start_i, in, 1: sample operands; accepted only in IDLE.
- done_o, out, 1: one-cycle pulse; result valid.
- op_a_i, in, DATA_W: dividend.
- op_b_i, in, DATA_W: divisor.
- overflow_o, out, 1: result overflowed to infinity.
- underflow_o, out, 1: result flushed to zero.
- exception_o, out, 1: invalid operation or divide-by-zero.
- res_o, out, DATA_W: quotient.

Behaviour:
- Reset (arst_n_i low, asynchronous): state IDLE; done_o, res_o and all flags = 0; internal registers cleared.
- Reset mid-operation aborts the operation; no done_o pulse is produced.
- FSM states: IDLE -> DIV -> RND -> IDLE.
- IDLE: on start_i=1, register operands, classify them, and pre-normalize: if man_a < man_b, shift man_a left by 1 and decrement the exponent. Go to DIV with the counter at MAN_W+2.
- DIV: each cycle, rem = rem - man_b if non-negative, else restore. Shift in one quotient bit and decrement the counter. Go to RND when the counter reaches 0. Quotient = MAN_W+2 bits (hidden, fraction, guard, round); sticky = (rem != 0).
- RND: iob_fp_round (RNE) on {quotient, sticky}. Register res_o and flags, pulse done_o, return to IDLE.
- Latency is fixed for all operands, special ones included: done_o rises on the (MAN_W+3)th rising edge after the edge sampling start_i (27 for defaults).
- Busy and handshake:
  - start_i is ignored outside IDLE.
  - A new start_i is accepted in the same cycle done_o is high (back-to-back).
  - Operands need to be valid only in the start cycle.
- Exponent arithmetic: signed, EXP_W+2 bits. e = Ea - Eb + BIAS - prenorm, plus 1 if rounding carries out.
  - e >= 2^EXP_W - 1: res = INF(sign), overflow_o = 1.
  - e <= 0: res = signed zero, underflow_o = 1 (no subnormal output).
- Sign = sign_a ^ sign_b for every result except NaN.
- Subnormal inputs are treated as zero.
- Special cases (priority order), with exception_o set where noted:
  - Any NaN -> canonical NaN {0, all-ones exponent, 1, zeros}; exception_o = 1.
  - inf/inf or 0/0 -> canonical NaN; exception_o = 1.
  - finite/0 -> INF(sign); exception_o = 1.
  - inf/x -> INF(sign).
  - x/inf or 0/x -> signed zero.
- res_o and flags hold from done_o until the next RND completion; flags are mutually consistent with res_o.

Decomposition:
- Shared package (iob_fp_pkg): MAN_W, BIAS and EXTRA derivations; NAN and INF constants; FSM state encodings (IDLE/DIV/RND, 2 bits).
- Reuse existing iob_fp_special (one instance per operand) and iob_fp_round.
- One natural new sub-module: iob_fp_div_man, the iterative restoring mantissa divider with counter, quotient shift register and sticky output. The top level keeps the FSM, exponent logic, specials and packing.

Test Plan:
- 0x40C00000 / 0x40000000 (6.0/2.0) -> res_o = 0x40400000; done_o exactly 27 edges after start; all flags 0.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB (RNE round-up via guard/sticky). 0xC0000000 / 0x3F800000 -> 0xC0000000.
- Specials:
  - 0x3F800000 / 0x00000000 -> 0x7F800000, exception_o = 1.
  - 0x00000000 / 0x00000000 -> 0x7FC00000, exception_o = 1.
  - 0x7FC00001 / 1.0 -> 0x7FC00000.
  - All still at 27-cycle latency.
- Range:
  - 0x7F000000 / 0x3E800000 -> 0x7F800000, overflow_o = 1.
  - 0x00800000 / 0x40000000 -> 0x00000000, underflow_o = 1.
- Handshake:
  - start_i pulsed during DIV is ignored (a single done_o).
  - start asserted in the done_o cycle yields a second result 27 edges later.
- Reset: arst_n_i low at cycle 10 of an operation -> outputs 0 immediately, no done_o.
  - A subsequent 6.0/2.0 completes correctly.
